// File: rtl/pwd_pkg.sv
// Shared definitions for the pulse-width decoder: state encoding, default width
// and the input latency that depends on PWD_SYNC_EN.
package pwd_pkg;

   localparam int CNT_W_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_LISTEN  = 3'd2,
      ST_MEASURE = 3'd3,
      ST_REPORT  = 3'd4
   } pwd_state_e;

   // Edges from pulse_in first sampled low to valid high.
`ifdef PWD_SYNC_EN
   localparam int PWD_LAT = 3;
`else
   localparam int PWD_LAT = 1;
`endif

endpackage

// File: rtl/pwd_sync.sv
// Two-flop synchroniser for the asynchronous pulse input (used under PWD_SYNC_EN).
module pwd_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic q_r;

   // Two-stage capture; the first stage may go metastable and gets a full cycle to settle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_r <= 1'b0;
         q_r    <= 1'b0;
      end else begin
         meta_r <= d;
         q_r    <= meta_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/pulse_width_decoder.sv
// Measures the high time of pulse_in and reports (high cycles - 1), saturating with err.
// Define PWD_SYNC_EN to pass pulse_in through a 2-flop synchroniser first.
module pulse_width_decoder
   import pwd_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] width_out,
   output logic             valid,
   output logic             err,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   logic             s_s;
   pwd_state_e       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             ovf_r;
   logic [CNT_W-1:0] width_r;
   logic             err_r;
   logic             valid_r;
   logic             busy_r;

`ifdef PWD_SYNC_EN
   pwd_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pulse_in),
      .q     (s_s)
   );
`else
   assign s_s = pulse_in;
`endif

   // Measurement FSM; busy_r tracks whether the next state is MEASURE so it stays registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         ovf_r   <= 1'b0;
         width_r <= CNT_ZERO;
         err_r   <= 1'b0;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         if (!enable) begin
            state_r <= ST_IDLE;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_ARM;
               end
               ST_ARM: begin
                  if (!s_s) begin
                     state_r <= ST_LISTEN;
                  end
               end
               ST_LISTEN: begin
                  if (s_s) begin
                     state_r <= ST_MEASURE;
                     cnt_r   <= CNT_ZERO;
                     ovf_r   <= 1'b0;
                     busy_r  <= 1'b1;
                  end
               end
               ST_MEASURE: begin
                  if (s_s) begin
                     busy_r <= 1'b1;
                     if (cnt_r == CNT_MAX) begin
                        ovf_r <= 1'b1;
                     end else begin
                        cnt_r <= cnt_r + 1'b1;
                     end
                  end else begin
                     state_r <= ST_REPORT;
                     width_r <= cnt_r;
                     err_r   <= ovf_r;
                     valid_r <= 1'b1;
                  end
               end
               ST_REPORT: begin
                  // A single low cycle is a legal gap, so a new pulse can start right here.
                  if (s_s) begin
                     state_r <= ST_MEASURE;
                     cnt_r   <= CNT_ZERO;
                     ovf_r   <= 1'b0;
                     busy_r  <= 1'b1;
                  end else begin
                     state_r <= ST_LISTEN;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign width_out = width_r;
   assign valid     = valid_r;
   assign err       = err_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Self-checking bench for pulse_width_decoder: directed scenarios plus random pulse trains
// scored against a pulse-level model (width, err and strobe cycle per pulse).
module tb_pulse_width_decoder;
   import pwd_pkg::*;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic         pulse_in;
   logic [W-1:0] width_out;
   logic         valid;
   logic         err;
   logic         busy;

   typedef struct {
      int cyc;
      int w;
      int e;
   } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  cyc        = 0;
   int  busy_cnt   = 0;
   int  compared   = 0;
   int  mismatched = 0;

   pulse_width_decoder #(.CNT_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .pulse_in  (pulse_in),
      .width_out (width_out),
      .valid     (valid),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive pulse_in, sample just after the edge, log strobes and busy cycles.
   task automatic cycle(input logic p);
      ev_t ev;
      pulse_in = p;
      @(posedge clk);
      #1;
      cyc++;
      if (valid === 1'b1) begin
         ev.cyc = cyc;
         ev.w   = int'(width_out);
         ev.e   = int'(err);
         obs_q.push_back(ev);
      end
      if (busy === 1'b1) busy_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0);
   endtask

   // Pulse-level model: n high cycles decode to min(n-1, max), err when n > 2^W,
   // strobe PWD_LAT-1 edges after the edge that first samples the low level.
   task automatic send_pulse(input int n, input int gap, input bit measured);
      ev_t ev;
      int  c0;
      c0 = cyc + 1;
      if (measured) begin
         ev.cyc = c0 + n + PWD_LAT - 1;
         ev.w   = (n - 1 > MAXV) ? MAXV : n - 1;
         ev.e   = (n > MAXV + 1) ? 1 : 0;
         exp_q.push_back(ev);
      end
      for (int i = 0; i < n; i++) cycle(1'b1);
      for (int i = 0; i < gap; i++) cycle(1'b0);
   endtask

   task automatic check_sb(input string tag);
      ev_t o;
      ev_t e;
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_cyc"}, o.cyc, e.cyc);
         chk({tag, "_width"}, o.w, e.w);
         chk({tag, "_err"}, o.e, e.e);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b0;
      pulse_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_width", width_out, 0);
      chk("rst_valid", valid, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_state", dut.state_r, ST_IDLE);

      // Basic 6-cycle pulse.
      enable = 1'b1;
      idle(5);
      busy_cnt = 0;
      send_pulse(6, 6, 1'b1);
      chk("p6_busy_cycles", busy_cnt, 6);
      check_sb("p6");

      // Saturation boundary: 16 is legal, 17 overflows; results hold afterwards.
      send_pulse(16, 6, 1'b1);
      idle(4);
      chk("p16_hold_width", width_out, 15);
      chk("p16_hold_err", err, 0);
      send_pulse(17, 6, 1'b1);
      idle(4);
      chk("p17_hold_width", width_out, 15);
      chk("p17_hold_err", err, 1);
      check_sb("sat");

      // Pulse already high when enable rises is ignored.
      enable = 1'b0;
      idle(2);
      for (int i = 0; i < 3; i++) cycle(1'b1);
      enable = 1'b1;
      for (int i = 0; i < 5; i++) cycle(1'b1);
      idle(5);
      send_pulse(3, 6, 1'b1);
      check_sb("arm");

      // Back-to-back pulses with a single low cycle between them.
      send_pulse(4, 1, 1'b1);
      send_pulse(2, 6, 1'b1);
      check_sb("b2b");

      // enable dropped mid-measurement: no strobe, outputs keep the previous value.
      busy_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == PWD_LAT + 1) enable = 1'b0;
         if (i == 8) enable = 1'b1;
         cycle(1'b1);
         if (i == 7) chk("abort_state", dut.state_r, ST_IDLE);
      end
      chk("abort_busy_cycles", busy_cnt, 2);
      idle(6);
      chk("abort_width", width_out, 1);
      chk("abort_err", err, 0);
      check_sb("abort");

      // Asynchronous reset between edges during MEASURE.
      for (int i = 0; i < PWD_LAT + 2; i++) cycle(1'b1);
      chk("pre_rst_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_width", width_out, 0);
      chk("arst_valid", valid, 0);
      chk("arst_err", err, 0);
      chk("arst_busy", busy, 0);
      chk("arst_state", dut.state_r, ST_IDLE);
      @(posedge clk);
      #1;
      cyc++;
      pulse_in = 1'b0;
      reset    = 1'b0;
      idle(5);
      send_pulse(4, 6, 1'b1);
      check_sb("post_rst");

      // Random pulse trains.
      for (int k = 0; k < 25; k++) begin
         send_pulse(int'($urandom_range(20, 1)), int'($urandom_range(4, 1)), 1'b1);
      end
      idle(6);
      check_sb("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pulse_width_decoder.md
# pulse_width_decoder

Receive-side counterpart of the pulse-width encoder: measures the high time of an incoming single-bit pulse and recovers the encoded value. A pulse held high for N+1 clock cycles decodes to width N, matching the encoder's convention (data_in = N gives N+1 high cycles). The block sits on the dedicated input pins and feeds a registered value, a one-cycle valid strobe and an overflow flag to downstream logic.

## Interface
- CNT_W, 4: width of the decoded value; maximum decodable value is 2^CNT_W-1.
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  measurement enable; low forces IDLE.
- pulse_in  input  1  pulse to be measured.
- width_out  output  CNT_W  last decoded value, high cycles minus one; held until next report.
- valid  output  1  one-cycle strobe; width_out/err updated in the same cycle.
- err  output  1  overflow: pulse exceeded 2^CNT_W high cycles; held with width_out.
- busy  output  1  high while in MEASURE.

## Operation
- s = sampled pulse_in, from the synchroniser (see Configuration).
- States: IDLE, ARM, LISTEN, MEASURE, REPORT.
- IDLE: enable=1 -> ARM.
- ARM: waits for s=0 so that a pulse already in progress is never measured. s=0 -> LISTEN.
- LISTEN: s=1 -> MEASURE, cnt<=0, ovf<=0.
- MEASURE: s=1 and cnt<max -> cnt+1. s=1 and cnt=max -> cnt holds, ovf<=1. s=0 -> REPORT, width_out<=cnt, err<=ovf, valid<=1.
- REPORT: valid high for this one cycle only. s=1 -> MEASURE with cnt<=0, so one low cycle between pulses is sufficient. Otherwise -> LISTEN.
- enable=0 in any state other than IDLE: go to IDLE next cycle. An aborted MEASURE produces no valid, and width_out/err are unchanged.
- Overflow: saturated result width_out = 2^CNT_W-1 with err=1. A pulse of exactly 2^CNT_W high cycles is legal: err=0.
- busy is decoded from state (MEASURE only).
- Reset values: width_out=0, valid=0, err=0, busy=0; state=IDLE, cnt=0, ovf=0, synchroniser flops=0. A reset during a measurement discards it.

## Timing
- With the synchroniser: s lags pulse_in by 2 cycles.
- valid rises on the 3rd rising edge after pulse_in is first sampled low (1 edge without the synchroniser).
- valid width: exactly 1 cycle. No back-pressure; the consumer must capture the value on the strobe.
- Minimum pulse: 1 high cycle, decodes to 0.
- Minimum low gap between pulses: 1 cycle.
- enable is used unsynchronised; it must be synchronous to clk.

## Configuration
- PWD_SYNC_EN defined: pulse_in passes through a 2-flop synchroniser before use. Latency is as stated in Timing.
- PWD_SYNC_EN undefined: pulse_in is used directly as s and must be synchronous to clk. Latency drops by 2 cycles; decoded values are identical.

## Structure
- Shared package pwd_pkg:
  - state encoding localparams (IDLE=0, ARM=1, LISTEN=2, MEASURE=3, REPORT=4; 3-bit).
  - default CNT_W.
  - the macro-dependent latency constant PWD_LAT (3 or 1) used by the bench.
- One sub-module, pwd_sync: 2-flop synchroniser with async active-high reset, instantiated only under PWD_SYNC_EN. The FSM and counter live in the top block.

## Test plan
- CNT_W=4, PWD_SYNC_EN set, enable=1, pulse_in high 6 cycles -> after PWD_LAT edges, a single valid with width_out=5, err=0. busy is high for the measurement.
- High 16 cycles -> width_out=15, err=0. High 17 cycles -> width_out=15, err=1. Both values hold after valid drops.
- pulse_in already high when enable rises -> no valid for that pulse. A following pulse of 3 cycles -> width_out=2.
- Back-to-back: high 4, low 1, high 2 -> two valid strobes, width_out=3 then 1, with no missed edges.
- enable dropped on the 3rd cycle of a 10-cycle pulse -> no valid, FSM in IDLE, width_out keeps its previous value.
- reset asserted mid-MEASURE, asynchronously between edges -> all outputs 0 immediately, state IDLE. The next full pulse of 4 cycles after release and re-arm -> width_out=3.
